seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The parameter PAT_W SHALL default to 8 and set the maximum pattern length in bits (legal range 2..32).
REQ-002 The parameter CNT_W SHALL default to 16 and set the match counter width.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock.
REQ-004 Port reset SHALL be an input, 1 bit wide, synchronous, active-high.
REQ-005 Port in SHALL be an input, 1 bit wide, and carry the serial data bit.
REQ-006 Port in_valid SHALL be an input, 1 bit wide; in is sampled only when in_valid=1.
REQ-007 Port cfg_load SHALL be an input, 1 bit wide, and latch new configuration.
REQ-008 Port cfg_pattern SHALL be an input, PAT_W bits wide; bit cfg_len-1 is the first bit received and bit 0 is the last.
REQ-009 Port cfg_len SHALL be an input, $clog2(PAT_W+1) bits wide, and give the pattern length.
REQ-010 Port cfg_overlap SHALL be an input, 1 bit wide: 1 = overlapping detection, 0 = non-overlapping.
REQ-011 Port out SHALL be an output, 1 bit wide, and carry the Mealy match pulse.
REQ-012 Port match_cnt SHALL be an output, CNT_W bits wide, and present only with SEQ_DET_MATCH_CNT_EN.

Function
REQ-013 The block SHALL hold the registers pattern, len, overlap, hist (PAT_W-1 bits) and fill (saturating at PAT_W-1).
REQ-014 out SHALL be combinational (Mealy): out = in_valid & run & (fill >= len-1) & ({hist[len-2:0], in} == pattern[len-1:0]).
REQ-015 out SHALL assert in the same cycle as the final pattern bit, with zero-cycle latency.
REQ-016 On a valid bit without a match, hist SHALL shift in the bit and fill SHALL increment, saturating.
REQ-017 On a match with overlap=1, hist SHALL shift and fill SHALL be retained, so suffix bits count toward the next match.
REQ-018 On a match with overlap=0, hist SHALL be cleared and fill SHALL be set to 0, so no bit of the match is reused.
REQ-019 When in_valid=0, hist and fill SHALL hold their values and out SHALL be 0.
REQ-020 The FSM SHALL have two states, IDLE and RUN; run=1 only in RUN.
REQ-021 IDLE SHALL move to RUN on a cfg_load with 1 <= cfg_len <= PAT_W.
REQ-022 RUN SHALL move to IDLE on a cfg_load with cfg_len = 0.
REQ-023 A cfg_load with cfg_len > PAT_W SHALL be clamped to PAT_W.
REQ-024 When len = 1, out SHALL equal in_valid & (in == pattern[0]), with no history needed.
REQ-025 When cfg_load and in_valid are both 1 in the same cycle, configuration SHALL win: the bit is ignored, out=0, and hist and fill are cleared.
REQ-026 cfg_load in RUN SHALL clear hist and fill; a partial match in progress is discarded.

Reset
REQ-027 Reset SHALL set state=RUN, pattern=3'b111 (zero-extended), len=3, overlap=0, hist=0 and fill=0; the post-reset default is a non-overlapping "111" detector.
REQ-028 out SHALL be 0 throughout any cycle with reset=1, regardless of in.
REQ-029 match_cnt SHALL be 0 after reset.
REQ-030 Reset SHALL have priority over cfg_load.

Configuration
REQ-031 With SEQ_DET_MATCH_CNT_EN defined, match_cnt SHALL increment on every cycle with out=1, saturate at all-ones, and clear only on reset or cfg_load.
REQ-032 Without SEQ_DET_MATCH_CNT_EN, the port match_cnt and its register SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-033 The package seq_det_pkg SHALL hold the state enum (IDLE, RUN), the reset constants (RST_PATTERN, RST_LEN) and a function that clamps len.
REQ-034 The module seq_det_hist SHALL be the single sub-module; it holds hist and fill, with shift, clear and hold controls.

Verification
REQ-035 After reset, stream in=1,1,1,1,1,1 with in_valid=1 -> out=1 on bits 3 and 6 only; match_cnt=2.
REQ-036 Load pattern=1011, len=4, overlap=1, then stream 1,0,1,1,0,1,1 -> out=1 on bits 4 and 7.
REQ-037 Same stream as REQ-036 with overlap=0 -> out=1 on bit 4 only.
REQ-038 Stream 1,0,1 with in_valid=0 gaps between bits and pattern=101, len=3 -> out=1 only on the third valid bit, and out=0 during every gap.
REQ-039 Drive cfg_load with in_valid=1 and in completing a pattern in the same cycle -> out=0, fill=0, match_cnt=0.
REQ-040 Load cfg_len=0 and stream 1s -> out stays 0; then load cfg_len=9 with PAT_W=8 -> len reads back as 8.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the configurable serial pattern detector:
//   - state_e      : detector FSM states (IDLE, RUN)
//   - RST_PATTERN  : pattern loaded at reset ("111", zero-extended)
//   - RST_LEN      : pattern length loaded at reset
//   - clamp_len()  : limits a requested pattern length to the hardware maximum
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [31:0] RST_PATTERN = 32'b111;
    localparam int          RST_LEN     = 3;

    // Requests longer than the history can hold are clamped to max_len.
    function automatic int clamp_len(input int raw_len, input int max_len);
        return (raw_len > max_len) ? max_len : raw_len;
    endfunction

endpackage : seq_det_pkg

// File: rtl/seq_det_hist.sv
// -----------------------------------------------------------------------------
// seq_det_hist
// Bit history for the serial pattern detector. Holds the last PAT_W-1 accepted
// bits (newest in bit 0) and a saturating count of how many of them are valid.
//
// Ports
//   clk          : clock
//   reset        : synchronous, active-high; clears history and fill
//   bit_i        : serial bit to shift in
//   shift_i      : shift bit_i into the history
//   clear_i      : clear history and fill (wins over shift_i)
//   hold_fill_i  : while shifting, keep fill unchanged instead of incrementing
//   hist_o       : history bits, bit 0 is the most recently accepted bit
//   fill_o       : number of valid history bits, saturating at PAT_W-1
// With neither shift_i nor clear_i asserted, both registers hold.
// -----------------------------------------------------------------------------
module seq_det_hist #(
    parameter int PAT_W  = 8,
    parameter int FILL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic              hold_fill_i,
    output logic [PAT_W-2:0]  hist_o,
    output logic [FILL_W-1:0] fill_o
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves a value unassigned and infers a latch.
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            // Dropping the oldest bit: keep the low PAT_W-1 bits of {hist, bit}.
            hist_d = (PAT_W - 1)'({hist_q, bit_i});
            if (!hold_fill_i && fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its next value from the same pre-edge snapshot.
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist_o = hist_q;
    assign fill_o = fill_q;

endmodule : seq_det_hist

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Runtime-configurable serial pattern detector with a Mealy match output.
// A pattern of 1..PAT_W bits is compared against the newest accepted bits plus
// the bit on the input this cycle; matches may overlap or be non-overlapping.
//
// Ports
//   clk          : single clock
//   reset        : synchronous, active-high; restores a non-overlapping "111"
//                  detector in RUN
//   in           : serial data bit
//   in_valid     : in is accepted only when 1
//   cfg_load     : latch cfg_pattern/cfg_len/cfg_overlap, clear history
//   cfg_pattern  : pattern, bit cfg_len-1 is received first, bit 0 last
//   cfg_len      : pattern length; 0 stops detection (IDLE), >PAT_W clamps
//   cfg_overlap  : 1 = overlapping matches, 0 = non-overlapping
//   out          : combinational match pulse, same cycle as the final bit
//   match_cnt    : saturating match counter, only with SEQ_DET_MATCH_CNT_EN
//
// Build option: define SEQ_DET_MATCH_CNT_EN to add the match_cnt port/counter.
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in,
    input  logic                         in_valid,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    output logic                         out
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt
`endif
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_params
        $error("seq_detector_param: PAT_W must be 2..32 and CNT_W >= 1");
    end

    state_e           state_q;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic             overlap_q;

    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;

    logic             run;
    logic             bit_take;
    logic             enough_hist;
    logic             pat_hit;
    logic             consume;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;

    // ------------------------------------------------------------------
    // Match evaluation
    // ------------------------------------------------------------------
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end

        run      = (state_q == RUN);
        window   = {hist, in};
        pat_hit  = ((window ^ pattern_q) & len_mask) == '0;
        // fill >= len-1, written without subtracting so len=0 cannot wrap.
        enough_hist = ((LEN_W + 1)'(fill) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len_q);

        // A configuration load owns the cycle: the data bit is discarded.
        bit_take = in_valid & run & ~cfg_load & ~reset;
        out      = bit_take & enough_hist & pat_hit;
        // Non-overlapping matches consume every bit of the match.
        consume  = out & ~overlap_q;
    end

    seq_det_hist #(
        .PAT_W  (PAT_W),
        .FILL_W (LEN_W)
    ) u_hist (
        .clk         (clk),
        .reset       (reset),
        .bit_i       (in),
        .shift_i     (bit_take & ~consume),
        .clear_i     (cfg_load | consume),
        .hold_fill_i (out),
        .hist_o      (hist),
        .fill_o      (fill)
    );

    // ------------------------------------------------------------------
    // Configuration registers and IDLE/RUN state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pattern_q <= PAT_W'(RST_PATTERN);
            len_q     <= LEN_W'(clamp_len(RST_LEN, PAT_W));
            overlap_q <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            overlap_q <= cfg_overlap;
            case (state_q)
                IDLE: if (cfg_len != '0) state_q <= RUN;
                RUN:  if (cfg_len == '0) state_q <= IDLE;
            endcase
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || cfg_load) begin
            cnt_q <= '0;
        end else if (out && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed scenarios followed by randomized traffic, all compared against a
// reference model that keeps the accepted bits in a queue and matches the
// newest len bits against the pattern.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_s;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       out_s;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt_s;
`endif

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_s),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .out         (out_s)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt_s)
`endif
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    logic       hq[$];
    int         m_len;
    logic [7:0] m_pat;
    logic       m_ovl;
    logic       m_run;
    int         m_cnt;

    logic [7:0] vec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Does the newest m_len bits (queue history plus bit b) equal the pattern?
    function automatic logic model_out(input logic b, input logic v, input logic ld, input logic rst);
        int   n;
        logic cur;
        if (rst || ld || !v || !m_run) return 1'b0;
        n = hq.size();
        if (n + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            cur = (k == m_len - 1) ? b : hq[n - (m_len - 1) + k];
            if (cur !== m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_update(input logic b, input logic v, input logic ld,
                                         input logic [7:0] pat, input logic [3:0] ln,
                                         input logic ov, input logic rst, input logic hit);
        if (rst) begin
            m_run = 1'b1; m_pat = 8'b111; m_len = 3; m_ovl = 1'b0; m_cnt = 0;
            hq.delete();
        end else if (ld) begin
            m_len = (int'(ln) > PAT_W) ? PAT_W : int'(ln);
            m_pat = pat; m_ovl = ov; m_run = (m_len != 0); m_cnt = 0;
            hq.delete();
        end else if (v && m_run) begin
            if (hit) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!m_ovl) hq.delete();
                else hq.push_back(b);
            end else begin
                hq.push_back(b);
            end
            if (hq.size() > 40) void'(hq.pop_front());
        end
    endfunction

    // One clock: drive at the falling edge, compare out mid-cycle, advance model.
    task automatic step(input logic b, input logic v, input logic ld, input logic [7:0] pat,
                        input logic [3:0] ln, input logic ov, input logic rst);
        logic obs, exp;
        in_s = b; in_valid = v; cfg_load = ld; cfg_pattern = pat;
        cfg_len = ln; cfg_overlap = ov; reset = rst;
        #1;
        obs = out_s;
        exp = model_out(b, v, ld, rst);
        check("out_vs_model", 32'(obs), 32'(exp));
        vec = {vec[6:0], obs};
        @(posedge clk);
        model_update(b, v, ld, pat, ln, ov, rst, exp);
        #1;
`ifdef SEQ_DET_MATCH_CNT_EN
        check("match_cnt_vs_model", 32'(match_cnt_s), 32'(m_cnt));
`endif
        @(negedge clk);
    endtask

    task automatic feed(input logic b);
        step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic gap(input logic b);
        step(b, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
        step(1'b0, 1'b0, 1'b1, pat, ln, ov, 1'b0);
    endtask

    task automatic feed_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) feed(bits[i]);
    endtask

    initial begin
        in_s = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
        cfg_len = '0; cfg_overlap = 1'b0; reset = 1'b1;
        m_run = 1'b0; m_len = 0; m_pat = '0; m_ovl = 1'b0; m_cnt = 0;
        @(negedge clk);

        // Reset with a live 1-stream: out must stay low.
        vec = '0;
        step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
        check("reset_out_low", 32'(vec), 32'h0);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("reset_cnt_zero", 32'(match_cnt_s), 32'h0);
`endif

        // Default "111" non-overlapping on six ones: hits on bits 3 and 6.
        vec = '0;
        for (int i = 0; i < 6; i++) feed(1'b1);
        check("default_111_stream", 32'(vec), 32'b001001);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("default_111_cnt", 32'(match_cnt_s), 32'd2);
`endif

        // 1011 overlapping: hits on bits 4 and 7.
        load(8'b1011, 4'd4, 1'b1);
        vec = '0;
        feed_bits(8'b1011011, 7);
        check("p1011_overlap", 32'(vec), 32'b0001001);

        // 1011 non-overlapping: hit on bit 4 only.
        load(8'b1011, 4'd4, 1'b0);
        vec = '0;
        feed_bits(8'b1011011, 7);
        check("p1011_nonoverlap", 32'(vec), 32'b0001000);

        // 101 with idle gaps carrying in=1: only the third valid bit hits.
        load(8'b101, 4'd3, 1'b0);
        vec = '0;
        feed(1'b1); gap(1'b1); feed(1'b0); gap(1'b1); feed(1'b1); gap(1'b1);
        check("p101_gaps", 32'(vec), 32'b000010);

        // Load in the same cycle as a completing bit: bit dropped, history cleared.
        feed(1'b1); feed(1'b0);
        vec = '0;
        step(1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b0, 1'b0);
        check("load_vs_bit_out", 32'(vec), 32'h0);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("load_vs_bit_cnt", 32'(match_cnt_s), 32'h0);
`endif
        vec = '0;
        feed(1'b1); feed(1'b0); feed(1'b1);
        check("load_clears_hist", 32'(vec), 32'b001);

        // Length 0 stops detection; length 9 clamps to 8.
        load(8'hFF, 4'd0, 1'b0);
        vec = '0;
        for (int i = 0; i < 4; i++) feed(1'b1);
        check("len0_idle", 32'(vec), 32'h0);
        load(8'hFF, 4'd9, 1'b0);
        vec = '0;
        for (int i = 0; i < 8; i++) feed(1'b1);
        check("len9_clamped_to_8", 32'(vec), 32'b00000001);

        // Length 1 needs no history.
        load(8'h01, 4'd1, 1'b0);
        vec = '0;
        feed(1'b1); feed(1'b0); feed(1'b1);
        check("len1_direct", 32'(vec), 32'b101);

        // Reset wins over a simultaneous load: back to the "111" detector.
        step(1'b0, 1'b0, 1'b1, 8'h01, 4'd1, 1'b0, 1'b1);
        vec = '0;
        feed(1'b1); feed(1'b1); feed(1'b1);
        check("reset_beats_load", 32'(vec), 32'b001);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] rp;
            logic [3:0] rl;
            rp = 8'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 4));
            if ($urandom_range(0, 199) == 0) begin
                step(1'($urandom), 1'($urandom), 1'($urandom), rp, rl, 1'($urandom), 1'b1);
            end else if ($urandom_range(0, 39) == 0) begin
                step(1'($urandom), 1'($urandom), 1'b1, rp, rl, 1'($urandom), 1'b0);
            end else begin
                step(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_seq_detector_param
